// File: rtl/microstep_sequencer.sv
// SAP-1 style controller/sequencer: step generation (auto divider or debounced manual
// button), one-hot T-state ring with optional early end, HLT latch and control decode.
module microstep_sequencer #(
    parameter int OPCODE_W      = 4,
    parameter int NUM_T         = 6,
    parameter int CLK_DIV       = 4,
    parameter int DebounceDelay = 8,
    parameter int EARLY_END     = 1
) (
    input  logic                base_clock,
    input  logic                CLR_bar,
    input  logic [OPCODE_W-1:0] instruction_input,
    input  logic                S6_SingleStep_pb,
    input  logic                S7_ManualAuto_sw,
    output logic                step,
    output logic [NUM_T-1:0]    t_state,
    output logic                halted,
    output logic                Cp,
    output logic                Ep,
    output logic                Su,
    output logic                Ea,
    output logic                Eu,
    output logic                Lm_bar,
    output logic                CE_bar,
    output logic                Li_bar,
    output logic                Ei_bar,
    output logic                La_bar,
    output logic                Lb_bar,
    output logic                Lo_bar
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DEB_W = $clog2(DebounceDelay) + 1;
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    logic             s7_meta_r, s7_sync_r, s7_prev_r;
    logic             s6_meta_r, s6_sync_r;
    logic             deb_level_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DIV_W-1:0] div_r;
    logic             step_r, halted_r, ctrl_en_r;
    logic [NUM_T-1:0] t_state_r, t_next_s;
    logic             mode_change_s, deb_differ_s, deb_flip_s, deb_rise_s;
    logic             hlt_now_s, at_last_s, step_req_s, step_next_s;
    logic [11:0]      act_s;

    assign mode_change_s = s7_sync_r ^ s7_prev_r;
    assign deb_differ_s  = s6_sync_r ^ deb_level_r;
    assign deb_flip_s    = deb_differ_s && (deb_cnt_r == DEB_W'(DebounceDelay - 1));
    assign deb_rise_s    = deb_flip_s && !deb_level_r;
    assign hlt_now_s     = t_state_r[3] && (instruction_input == OP_HLT);
    assign step_next_s   = step_req_s && !halted_r && !hlt_now_s;

    // Synchronisers, mode tracking, debouncer and auto divider
    always_ff @(posedge base_clock) begin
        if (!CLR_bar) begin
            s7_meta_r   <= 1'b0;
            s7_sync_r   <= 1'b0;
            s7_prev_r   <= 1'b0;
            s6_meta_r   <= 1'b0;
            s6_sync_r   <= 1'b0;
            deb_level_r <= 1'b0;
            deb_cnt_r   <= '0;
            div_r       <= '0;
        end else begin
            s7_meta_r <= S7_ManualAuto_sw;
            s7_sync_r <= s7_meta_r;
            s7_prev_r <= s7_sync_r;
            s6_meta_r <= S6_SingleStep_pb;
            s6_sync_r <= s6_meta_r;
            if (deb_flip_s) begin
                deb_level_r <= ~deb_level_r;
                deb_cnt_r   <= '0;
            end else if (deb_differ_s) begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end else begin
                deb_cnt_r <= '0;
            end
            if (mode_change_s || !s7_sync_r || (div_r == DIV_W'(CLK_DIV - 1))) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Step request: a mode change swallows whatever would have fired this cycle
    always_comb begin
        step_req_s = 1'b0;
        if (mode_change_s) begin
            step_req_s = 1'b0;
        end else if (s7_sync_r) begin
            step_req_s = (div_r == DIV_W'(CLK_DIV - 1));
        end else begin
            step_req_s = deb_rise_s;
        end
    end

    // Last active state of the current opcode
    always_comb begin
        at_last_s = 1'b0;
        case (instruction_input)
            OP_LDA, OP_ADD, OP_SUB: at_last_s = t_state_r[5];
            OP_OUT, OP_HLT:         at_last_s = t_state_r[3];
            default:                at_last_s = t_state_r[2];
        endcase
    end

    // State register: step pulse, T-state ring, halt latch, control enable
    always_ff @(posedge base_clock) begin
        if (!CLR_bar) begin
            step_r    <= 1'b0;
            t_state_r <= NUM_T'(1);
            halted_r  <= 1'b0;
            ctrl_en_r <= 1'b0;
        end else begin
            step_r    <= step_next_s;
            t_state_r <= t_next_s;
            halted_r  <= halted_r | hlt_now_s;
            ctrl_en_r <= 1'b1;
        end
    end

    // Next T-state: rotate on step, or wrap early after the opcode's last state
    always_comb begin
        t_next_s = t_state_r;
        if (step_r && !halted_r && !hlt_now_s) begin
            if ((EARLY_END != 0) && at_last_s) begin
                t_next_s = NUM_T'(1);
            end else begin
                t_next_s = {t_state_r[NUM_T-2:0], t_state_r[NUM_T-1]};
            end
        end else begin
            t_next_s = t_state_r;
        end
    end

    // Control decode, active-high mask {Cp,Ep,Su,Ea,Eu,Lm,CE,Li,Ei,La,Lb,Lo}
    always_comb begin
        act_s = 12'h000;
        if (t_state_r[0]) begin
            act_s = 12'h440;
        end else if (t_state_r[1]) begin
            act_s = 12'h800;
        end else if (t_state_r[2]) begin
            act_s = 12'h030;
        end else if (t_state_r[3]) begin
            case (instruction_input)
                OP_LDA, OP_ADD: act_s = 12'h048;
                OP_SUB:         act_s = 12'h248;
                OP_OUT:         act_s = 12'h101;
                default:        act_s = 12'h000;
            endcase
        end else if (t_state_r[4]) begin
            case (instruction_input)
                OP_LDA:  act_s = 12'h024;
                OP_ADD:  act_s = 12'h022;
                OP_SUB:  act_s = 12'h222;
                default: act_s = 12'h000;
            endcase
        end else if (t_state_r[5]) begin
            case (instruction_input)
                OP_ADD:  act_s = 12'h084;
                OP_SUB:  act_s = 12'h284;
                default: act_s = 12'h000;
            endcase
        end else begin
            act_s = 12'h000;
        end
    end

    assign step    = step_r;
    assign t_state = t_state_r;
    assign halted  = halted_r;
    assign Cp      = ctrl_en_r & act_s[11];
    assign Ep      = ctrl_en_r & act_s[10];
    assign Su      = ctrl_en_r & act_s[9];
    assign Ea      = ctrl_en_r & act_s[8];
    assign Eu      = ctrl_en_r & act_s[7];
    assign Lm_bar  = ~(ctrl_en_r & act_s[6]);
    assign CE_bar  = ~(ctrl_en_r & act_s[5]);
    assign Li_bar  = ~(ctrl_en_r & act_s[4]);
    assign Ei_bar  = ~(ctrl_en_r & act_s[3]);
    assign La_bar  = ~(ctrl_en_r & act_s[2]);
    assign Lb_bar  = ~(ctrl_en_r & act_s[1]);
    assign Lo_bar  = ~(ctrl_en_r & act_s[0]);
endmodule

// File: tb/tb_microstep_sequencer.sv
// Bench for microstep_sequencer: decode table, randomized auto run against a state-list
// model (early-end and full-length instances side by side), manual debounce and HLT cases.
module tb_microstep_sequencer;
    localparam int NT  = 6;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_bar, s6, s7;
    logic [3:0] instr;
    logic step_a, halted_a, step_b, halted_b;
    logic [NT-1:0] ts_a, ts_b;
    logic cp_a, ep_a, su_a, ea_a, eu_a, lm_a, ce_a, li_a, ei_a, la_a, lb_a, lo_a;
    logic cp_b, ep_b, su_b, ea_b, eu_b, lm_b, ce_b, li_b, ei_b, la_b, lb_b, lo_b;
    logic [11:0] act_a, act_b;

    assign act_a = {cp_a, ep_a, su_a, ea_a, eu_a, ~lm_a, ~ce_a, ~li_a, ~ei_a, ~la_a, ~lb_a, ~lo_a};
    assign act_b = {cp_b, ep_b, su_b, ea_b, eu_b, ~lm_b, ~ce_b, ~li_b, ~ei_b, ~la_b, ~lb_b, ~lo_b};

    microstep_sequencer #(.OPCODE_W(4), .NUM_T(NT), .CLK_DIV(DIV), .DebounceDelay(8), .EARLY_END(1)) dut (
        .base_clock(clk), .CLR_bar(clr_bar), .instruction_input(instr),
        .S6_SingleStep_pb(s6), .S7_ManualAuto_sw(s7),
        .step(step_a), .t_state(ts_a), .halted(halted_a),
        .Cp(cp_a), .Ep(ep_a), .Su(su_a), .Ea(ea_a), .Eu(eu_a),
        .Lm_bar(lm_a), .CE_bar(ce_a), .Li_bar(li_a), .Ei_bar(ei_a),
        .La_bar(la_a), .Lb_bar(lb_a), .Lo_bar(lo_a));

    microstep_sequencer #(.OPCODE_W(4), .NUM_T(NT), .CLK_DIV(DIV), .DebounceDelay(8), .EARLY_END(0)) dut_full (
        .base_clock(clk), .CLR_bar(clr_bar), .instruction_input(instr),
        .S6_SingleStep_pb(s6), .S7_ManualAuto_sw(s7),
        .step(step_b), .t_state(ts_b), .halted(halted_b),
        .Cp(cp_b), .Ep(ep_b), .Su(su_b), .Ea(ea_b), .Eu(eu_b),
        .Lm_bar(lm_b), .CE_bar(ce_b), .Li_bar(li_b), .Ei_bar(ei_b),
        .La_bar(la_b), .Lb_bar(lb_b), .Lo_bar(lo_b));

    typedef struct {
        logic [3:0]  op;
        int          st;
        logic [11:0] mask;
    } vec_t;

    vec_t vecs[16];
    logic [NT-1:0] va[7], vb[7];
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Number of states the opcode occupies before an early wrap
    function automatic int last_state(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2: return 6;
            4'd14, 4'd15:     return 4;
            default:          return 3;
        endcase
    endfunction

    // Expected active-control mask for opcode op in state st (1-based)
    function automatic logic [11:0] exp_mask(input logic [3:0] op, input int st);
        logic [11:0] fetch[3];
        logic [11:0] lda[3];
        logic [11:0] add[3];
        fetch = '{12'h440, 12'h800, 12'h030};
        lda   = '{12'h048, 12'h024, 12'h000};
        add   = '{12'h048, 12'h022, 12'h084};
        if (st <= 3) return fetch[st-1];
        if (st > 6) return 12'h000;
        case (op)
            4'd0:    return lda[st-4];
            4'd1:    return add[st-4];
            4'd2:    return add[st-4] | 12'h200;
            4'd14:   return (st == 4) ? 12'h101 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] ops[7];
        ops = '{4'd0, 4'd1, 4'd2, 4'd14, 4'd7, 4'd3, 4'd9};
        return ops[$urandom_range(6)];
    endfunction

    task automatic reset_dut(input logic s7v, input logic [3:0] op);
        s7 = s7v; s6 = 1'b0; instr = op; clr_bar = 1'b0;
        repeat (3) @(negedge clk);
        clr_bar = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ts(input bit use_b, input logic [NT-1:0] target, input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if ((use_b ? ts_b : ts_a) == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_step(input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if (step_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic visit(input logic [3:0] op);
        bit ok;
        reset_dut(1'b1, op);
        for (int k = 0; k < 7; k++) begin
            wait_step(30, ok);
            check("visit_step_timeout", 32'(ok), 32'd1);
            check("visit_step_b", 32'(step_b), 32'd1);
            check($sformatf("visit_a op%0d #%0d", op, k), 32'(ts_a), 32'(va[k]));
            check($sformatf("visit_b op%0d #%0d", op, k), 32'(ts_b), 32'(vb[k]));
            if (op == 4'd14 && k == 3) check("out_t4_ctrl", 32'(act_a), 32'h101);
            @(negedge clk);
        end
    endtask

    task automatic press(input int len, output int steps);
        steps = 0;
        s6 = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            steps += 32'(step_a);
        end
        s6 = 1'b0;
        repeat (25) begin
            @(negedge clk);
            steps += 32'(step_a);
        end
    endtask

    initial begin
        bit ok;
        int steps, ph, ta, tb, bad;
        int plens[3];
        logic es;

        // Reset held for three edges
        clr_bar = 1'b0; s6 = 1'b0; s7 = 1'b1; instr = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_t_state", 32'(ts_a), 32'd1);
        check("rst_t_state_b", 32'(ts_b), 32'd1);
        check("rst_halted", 32'(halted_a), 32'd0);
        check("rst_ctrl", 32'(act_a), 32'd0);
        check("rst_step", 32'(step_a), 32'd0);
        clr_bar = 1'b1;

        // Decode table on the full-length instance
        vecs[0]  = '{op: 4'd0,  st: 1, mask: 12'h440};
        vecs[1]  = '{op: 4'd0,  st: 2, mask: 12'h800};
        vecs[2]  = '{op: 4'd0,  st: 3, mask: 12'h030};
        vecs[3]  = '{op: 4'd0,  st: 4, mask: 12'h048};
        vecs[4]  = '{op: 4'd0,  st: 5, mask: 12'h024};
        vecs[5]  = '{op: 4'd0,  st: 6, mask: 12'h000};
        vecs[6]  = '{op: 4'd1,  st: 4, mask: 12'h048};
        vecs[7]  = '{op: 4'd1,  st: 5, mask: 12'h022};
        vecs[8]  = '{op: 4'd1,  st: 6, mask: 12'h084};
        vecs[9]  = '{op: 4'd2,  st: 4, mask: 12'h248};
        vecs[10] = '{op: 4'd2,  st: 5, mask: 12'h222};
        vecs[11] = '{op: 4'd2,  st: 6, mask: 12'h284};
        vecs[12] = '{op: 4'd14, st: 4, mask: 12'h101};
        vecs[13] = '{op: 4'd14, st: 5, mask: 12'h000};
        vecs[14] = '{op: 4'd7,  st: 4, mask: 12'h000};
        vecs[15] = '{op: 4'd9,  st: 6, mask: 12'h000};
        reset_dut(1'b1, 4'd0);
        foreach (vecs[i]) begin
            instr = vecs[i].op;
            wait_ts(1'b1, NT'(1 << (vecs[i].st - 1)), 40, ok);
            check($sformatf("tbl_reach %0d", i), 32'(ok), 32'd1);
            check($sformatf("tbl_ctrl %0d", i), 32'(act_b), 32'(vecs[i].mask));
        end

        // Early-end visit orders
        va = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd1, 6'd2, 6'd4};
        vb = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1};
        visit(4'd14);
        va = '{6'd1, 6'd2, 6'd4, 6'd1, 6'd2, 6'd4, 6'd1};
        visit(4'd7);

        // Randomized auto run against the model
        reset_dut(1'b1, 4'd0);
        wait_step(30, ok);
        check("align_timeout", 32'(ok), 32'd1);
        ph = 0; ta = 1; tb = 1;
        for (int c = 0; c < 600; c++) begin
            es = (ph == 0);
            check("m_step_a", 32'(step_a), 32'(es));
            check("m_step_b", 32'(step_b), 32'(es));
            check("m_ts_a", 32'(ts_a), 32'(1 << (ta - 1)));
            check("m_ts_b", 32'(ts_b), 32'(1 << (tb - 1)));
            check("m_ctrl_a", 32'(act_a), 32'(exp_mask(instr, ta)));
            check("m_ctrl_b", 32'(act_b), 32'(exp_mask(instr, tb)));
            if (ta == 1 && $urandom_range(3) == 0) instr = pick_op();
            if (es) begin
                ta = (ta >= last_state(instr)) ? 1 : ta + 1;
                tb = (tb >= NT) ? 1 : tb + 1;
            end
            ph = (ph + 1) % DIV;
            @(negedge clk);
        end

        // Manual: short pulses, bouncy long press, mode toggle during debounce
        reset_dut(1'b0, 4'd0);
        repeat (5) @(negedge clk);
        plens = '{1, 3, 7};
        foreach (plens[i]) begin
            press(plens[i], steps);
            check($sformatf("short_pulse_%0d", plens[i]), 32'(steps), 32'd0);
        end
        check("manual_still_t1", 32'(ts_a), 32'd1);
        steps = 0;
        va = '{6'd1, 6'd0, 6'd1, 6'd1, 6'd0, 6'd1, 6'd0};
        for (int k = 0; k < 7; k++) begin
            s6 = va[k][0];
            @(negedge clk);
            steps += 32'(step_a);
        end
        s6 = 1'b1;
        repeat (40) begin @(negedge clk); steps += 32'(step_a); end
        va = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0};
        for (int k = 0; k < 7; k++) begin
            s6 = va[k][0];
            @(negedge clk);
            steps += 32'(step_a);
        end
        repeat (25) begin @(negedge clk); steps += 32'(step_a); end
        check("bouncy_press_steps", 32'(steps), 32'd1);
        check("bouncy_press_t2", 32'(ts_a), 32'd2);
        steps = 0;
        s6 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) s7 = 1'b1;
            if (k == 6) s7 = 1'b0;
            @(negedge clk);
            steps += 32'(step_a);
        end
        s6 = 1'b0;
        repeat (25) begin @(negedge clk); steps += 32'(step_a); end
        check("s7_toggle_steps", 32'(steps), 32'd1);
        check("s7_toggle_t3", 32'(ts_a), 32'd4);

        // HLT latching and release by reset
        reset_dut(1'b1, 4'd15);
        wait_ts(1'b0, 6'd8, 60, ok);
        check("hlt_reach_t4", 32'(ok), 32'd1);
        check("hlt_not_yet", 32'(halted_a), 32'd0);
        @(negedge clk);
        check("hlt_set", 32'(halted_a), 32'd1);
        check("hlt_set_b", 32'(halted_b), 32'd1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ts_a != 6'd8 || ts_b != 6'd8 || step_a || step_b || !halted_a) bad++;
        end
        check("hlt_frozen_cycles_bad", 32'(bad), 32'd0);
        clr_bar = 1'b0;
        @(negedge clk);
        check("hlt_clr_t1", 32'(ts_a), 32'd1);
        check("hlt_clr_halted", 32'(halted_a), 32'd0);
        clr_bar = 1'b1;

        // Reset during T5 of ADD
        reset_dut(1'b1, 4'd1);
        wait_ts(1'b0, 6'd16, 60, ok);
        check("add_reach_t5", 32'(ok), 32'd1);
        check("add_t5_ctrl", 32'(act_a), 32'h022);
        clr_bar = 1'b0;
        @(negedge clk);
        check("midrst_t1", 32'(ts_a), 32'd1);
        check("midrst_t1_b", 32'(ts_b), 32'd1);
        check("midrst_ctrl", 32'(act_a), 32'd0);
        clr_bar = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
